// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT source-side capture path.
//   N_PTS    : points per FFT frame
//   DW       : width of real/imag samples (two's complement)
//   IDXW     : bin index width
//   EXPW     : block-exponent width
//   PW       : width of a bin power value (re^2 + im^2)
//   LAST_IDX : index of the final bin in a frame, in counter width
//   state_e  : frame-tracking FSM states
package fft_pkg;

    localparam int N_PTS = 1024;
    localparam int DW    = 14;
    localparam int IDXW  = 10;
    localparam int EXPW  = 6;
    localparam int PW    = 2 * DW + 1;

    localparam logic [IDXW:0] LAST_IDX = (IDXW + 1)'(N_PTS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_e;

endpackage

// File: rtl/fft_bin_power.sv
// One-stage registered bin power: pow_q <= re*re + im*im when en is high.
// The products are signed; both are non-negative, so the sum is carried as an
// unsigned PW-bit value. The largest result, 2*(2^(DW-1))^2, fits without
// overflow.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : load a new power value this edge
//   re, im     : signed sample parts
//   pow_q      : registered power
module fft_bin_power
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic signed [DW-1:0] re,
    input  logic signed [DW-1:0] im,
    output logic        [PW-1:0] pow_q
);

    logic signed [2*DW-1:0] re_sq_s;
    logic signed [2*DW-1:0] im_sq_s;
    logic        [PW-1:0]   pow_d;

    // Square both parts and form the next power value.
    always_comb begin
        re_sq_s = re * re;
        im_sq_s = im * im;
        if (en) begin
            pow_d = {1'b0, re_sq_s} + {1'b0, im_sq_s};
        end else begin
            pow_d = pow_q;
        end
    end

    // Power register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pow_q <= {PW{1'b0}};
        end else begin
            pow_q <= pow_d;
        end
    end

endmodule

// File: rtl/fft_source_capture.sv
// Avalon-ST sink for the FFT core's source port. It checks frame framing,
// tracks the peak-power bin and reports peak bin, power and block exponent
// once per good frame.
// Pipeline: edge k accepts a beat (power and flags registered), edge k+1
// updates the running best and makes the framing decision, and edge k+2
// drives the peak outputs and a one-cycle frame_done or frame_err pulse.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   source_valid/sop/eop/error/real/imag/exp : core output beat
//   hold               : downstream backpressure request
//   source_ready       : registered beat acceptance (~hold, one edge late)
//   peak_bin/pow/exp   : results of the last good frame
//   frame_done         : pulse, results updated
//   frame_err          : pulse, framing or core error
module fft_source_capture
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   source_valid,
    input  logic                   source_sop,
    input  logic                   source_eop,
    input  logic [1:0]             source_error,
    input  logic signed [DW-1:0]   source_real,
    input  logic signed [DW-1:0]   source_imag,
    input  logic [EXPW-1:0]        source_exp,
    input  logic                   hold,
    output logic                   source_ready,
    output logic [IDXW-1:0]        peak_bin,
    output logic [PW-1:0]          peak_pow,
    output logic [EXPW-1:0]        peak_exp,
    output logic                   frame_done,
    output logic                   frame_err
);

    logic            accept_s;
    logic [PW-1:0]   s1_pow_s;
    logic            better_s;
    logic [PW-1:0]   cand_pow_s;
    logic [IDXW-1:0] cand_bin_s;

    // Stage 1 beat flags
    logic ready_q, ready_d;
    logic s1_vld_q, s1_vld_d, s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d;
    logic s1_err_q, s1_err_d;
    logic [EXPW-1:0] s1_exp_q, s1_exp_d;

    // Stage 2 frame tracking
    state_e          state_q, state_d;
    logic [IDXW:0]   idx_q, idx_d;
    logic [PW-1:0]   best_pow_q, best_pow_d;
    logic [IDXW-1:0] best_bin_q, best_bin_d;
    logic            err_seen_q, err_seen_d;
    logic            done_pend_q, done_pend_d, err_pend_q, err_pend_d;
    logic [PW-1:0]   res_pow_q, res_pow_d;
    logic [IDXW-1:0] res_bin_q, res_bin_d;
    logic [EXPW-1:0] res_exp_q, res_exp_d;

    // Output stage
    logic [IDXW-1:0] peak_bin_q, peak_bin_d;
    logic [PW-1:0]   peak_pow_q, peak_pow_d;
    logic [EXPW-1:0] peak_exp_q, peak_exp_d;
    logic            frame_done_q, frame_done_d, frame_err_q, frame_err_d;

    assign accept_s = source_valid & ready_q;

    fft_bin_power u_power (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (accept_s),
        .re    (source_real),
        .im    (source_imag),
        .pow_q (s1_pow_s)
    );

    // Stage 1: ready tracking and capture of the accepted beat's flags.
    always_comb begin
        ready_d  = ~hold;
        s1_vld_d = accept_s;
        if (accept_s) begin
            s1_sop_d = source_sop;
            s1_eop_d = source_eop;
            s1_err_d = |source_error;
            s1_exp_d = source_exp;
        end else begin
            s1_sop_d = s1_sop_q;
            s1_eop_d = s1_eop_q;
            s1_err_d = s1_err_q;
            s1_exp_d = s1_exp_q;
        end
    end

    // Stage 2: running best and framing FSM. The bin index of the beat in
    // stage 1 is idx_q; ties keep the earlier (lower) bin.
    always_comb begin
        better_s    = s1_pow_s > best_pow_q;
        cand_pow_s  = better_s ? s1_pow_s : best_pow_q;
        cand_bin_s  = better_s ? idx_q[IDXW-1:0] : best_bin_q;
        state_d     = state_q;
        idx_d       = idx_q;
        best_pow_d  = best_pow_q;
        best_bin_d  = best_bin_q;
        err_seen_d  = err_seen_q;
        done_pend_d = 1'b0;
        err_pend_d  = 1'b0;
        res_pow_d   = res_pow_q;
        res_bin_d   = res_bin_q;
        res_exp_d   = res_exp_q;
        if (s1_vld_q && (s1_sop_q || state_q == IDLE)) begin
            // Frame start (from IDLE or as a restart). A restart reports the
            // aborted frame; sop together with eop is an early end, and both
            // cases fold into a single error pulse.
            if (s1_sop_q) begin
                err_pend_d = (state_q == FRAME) || s1_eop_q;
                state_d    = s1_eop_q ? IDLE : FRAME;
                idx_d      = (IDXW + 1)'(1);
                best_pow_d = s1_pow_s;
                best_bin_d = {IDXW{1'b0}};
                err_seen_d = s1_err_q;
            end else begin
                err_pend_d = 1'b1;
            end
        end else if (s1_vld_q) begin
            case (state_q)
                FRAME: begin
                    if (s1_eop_q) begin
                        state_d = IDLE;
                        if ((idx_q == LAST_IDX) && !(err_seen_q || s1_err_q)) begin
                            done_pend_d = 1'b1;
                            res_pow_d   = cand_pow_s;
                            res_bin_d   = cand_bin_s;
                            res_exp_d   = s1_exp_q;
                        end else begin
                            err_pend_d = 1'b1;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        state_d    = IDLE;
                        err_pend_d = 1'b1;
                    end else begin
                        idx_d      = idx_q + (IDXW + 1)'(1);
                        best_pow_d = cand_pow_s;
                        best_bin_d = cand_bin_s;
                        err_seen_d = err_seen_q | s1_err_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output stage: publish results of a good frame, pulse the status flags.
    always_comb begin
        frame_done_d = done_pend_q;
        frame_err_d  = err_pend_q;
        if (done_pend_q) begin
            peak_bin_d = res_bin_q;
            peak_pow_d = res_pow_q;
            peak_exp_d = res_exp_q;
        end else begin
            peak_bin_d = peak_bin_q;
            peak_pow_d = peak_pow_q;
            peak_exp_d = peak_exp_q;
        end
    end

    // All pipeline, FSM and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q      <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_sop_q     <= 1'b0;
            s1_eop_q     <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_exp_q     <= {EXPW{1'b0}};
            state_q      <= IDLE;
            idx_q        <= {(IDXW + 1){1'b0}};
            best_pow_q   <= {PW{1'b0}};
            best_bin_q   <= {IDXW{1'b0}};
            err_seen_q   <= 1'b0;
            done_pend_q  <= 1'b0;
            err_pend_q   <= 1'b0;
            res_pow_q    <= {PW{1'b0}};
            res_bin_q    <= {IDXW{1'b0}};
            res_exp_q    <= {EXPW{1'b0}};
            peak_bin_q   <= {IDXW{1'b0}};
            peak_pow_q   <= {PW{1'b0}};
            peak_exp_q   <= {EXPW{1'b0}};
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            ready_q      <= ready_d;
            s1_vld_q     <= s1_vld_d;
            s1_sop_q     <= s1_sop_d;
            s1_eop_q     <= s1_eop_d;
            s1_err_q     <= s1_err_d;
            s1_exp_q     <= s1_exp_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            best_pow_q   <= best_pow_d;
            best_bin_q   <= best_bin_d;
            err_seen_q   <= err_seen_d;
            done_pend_q  <= done_pend_d;
            err_pend_q   <= err_pend_d;
            res_pow_q    <= res_pow_d;
            res_bin_q    <= res_bin_d;
            res_exp_q    <= res_exp_d;
            peak_bin_q   <= peak_bin_d;
            peak_pow_q   <= peak_pow_d;
            peak_exp_q   <= peak_exp_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign source_ready = ready_q;
    assign peak_bin     = peak_bin_q;
    assign peak_pow     = peak_pow_q;
    assign peak_exp     = peak_exp_q;
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;

endmodule
